// File: rtl/rr_sel_5ch.sv
// Five-channel round-robin selector: one-entry buffer per channel feeding a registered output.
// Optional macro SEL_IDLE_EN drives selection to 3'd7 whenever out_valid is low.
module rr_sel_5ch #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       in_valid,
    input  logic [WIDTH-1:0] in_data0,
    input  logic [WIDTH-1:0] in_data1,
    input  logic [WIDTH-1:0] in_data2,
    input  logic [WIDTH-1:0] in_data3,
    input  logic [WIDTH-1:0] in_data4,
    output logic [4:0]       in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [2:0]       selection
);

`ifdef SEL_IDLE_EN
    localparam logic [2:0] SEL_RESET = 3'd7;
`else
    localparam logic [2:0] SEL_RESET = 3'd0;
`endif

    logic [4:0]       full_r;
    logic [WIDTH-1:0] buf_r [5];
    logic [2:0]       ptr_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    logic [2:0]       sel_r;

    logic [WIDTH-1:0] in_data_s [5];
    logic             out_free_s;
    logic             grant_s;
    logic             do_grant_s;
    logic [2:0]       grant_idx_s;

    // Addition modulo 5 for channel indices (operands are always 0..4).
    function automatic logic [2:0] mod5_add(input logic [2:0] a, input logic [2:0] b);
        logic [3:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= 4'd5) begin
            sum = sum - 4'd5;
        end else begin
            sum = sum;
        end
        return sum[2:0];
    endfunction

    assign in_data_s[0] = in_data0;
    assign in_data_s[1] = in_data1;
    assign in_data_s[2] = in_data2;
    assign in_data_s[3] = in_data3;
    assign in_data_s[4] = in_data4;

    assign out_free_s = ~out_valid_r | out_ready;
    assign do_grant_s = out_free_s & grant_s;

    // Find the first full channel searching from ptr with wrap 4->0.
    always_comb begin
        grant_s     = 1'b0;
        grant_idx_s = 3'd0;
        for (int k = 0; k < 5; k++) begin
            if (!grant_s && full_r[mod5_add(ptr_r, 3'(k))]) begin
                grant_s     = 1'b1;
                grant_idx_s = mod5_add(ptr_r, 3'(k));
            end else begin
                grant_s     = grant_s;
                grant_idx_s = grant_idx_s;
            end
        end
    end

    // Per-channel holding buffers; accept only when empty, so accept and grant never collide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_r <= 5'b00000;
            for (int i = 0; i < 5; i++) begin
                buf_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (in_valid[i] && !full_r[i]) begin
                    full_r[i] <= 1'b1;
                    buf_r[i]  <= in_data_s[i];
                end else if (do_grant_s && (grant_idx_s == 3'(i))) begin
                    full_r[i] <= 1'b0;
                end
            end
        end
    end

    // Output register, selection code and round-robin pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {WIDTH{1'b0}};
            sel_r       <= SEL_RESET;
            ptr_r       <= 3'd0;
        end else if (out_free_s) begin
            if (grant_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= buf_r[grant_idx_s];
                sel_r       <= grant_idx_s;
                ptr_r       <= mod5_add(grant_idx_s, 3'd1);
            end else begin
                out_valid_r <= 1'b0;
`ifdef SEL_IDLE_EN
                sel_r       <= 3'd7;
`endif
            end
        end
    end

    assign in_ready  = ~full_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign selection = sel_r;

endmodule
